wb_cmd_master: RTL

// - Wishbone initiator. Drives the single master port (m0) of the wishbone interconnect from a valid/ready command channel.
// - Issues one classic single-beat read or write per command and returns a response (data, err, timeout).
// - Sits between a host/test controller and the interconnect. Bounds every bus cycle with a timeout so an unmapped or hung slave cannot lock the host.

---
 rtl/wb_cmd_master_if.sv | 39 +++
 rtl/wb_cmd_master.sv | 99 +++++++++
 2 files changed

// File: rtl/wb_cmd_master_if.sv
// Command/response channel plus Wishbone master bus for wb_cmd_master.
// master: the initiator's view; slave: the host-plus-slave side that drives it.
`timescale 1ns/1ps
interface wb_cmd_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_tout_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tout_o,
    output wbm_dat_o, wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tout_o,
    input  wbm_dat_o, wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone initiator with bus-cycle timeout; accept->stb 1 cycle, ack->rsp 1 cycle.
// Backpressure: one command in flight; cmd_ready low until the response is consumed.
`timescale 1ns/1ps
module wb_cmd_master #(
  parameter int TOUT_CYC = 255,
  parameter int TOUT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_cmd_master_if.master   bus,
  output logic [7:0]        tout_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TOUT_W-1:0] cnt;
  logic              accept;
  logic              term_err;
  logic              term_ack;
  logic              term_tout;
  logic              bus_done;
  logic              rsp_hs;

  always_comb begin
    accept    = (state == IDLE) && bus.cmd_valid_i;
    term_err  = (state == BUS) && bus.wbm_err_i;
    term_ack  = (state == BUS) && bus.wbm_ack_i && !bus.wbm_err_i;
    term_tout = (state == BUS) && !bus.wbm_ack_i && !bus.wbm_err_i &&
                (cnt == TOUT_W'(TOUT_CYC - 1));
    bus_done  = term_err || term_ack || term_tout;
    rsp_hs    = (state == RESP) && bus.rsp_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = BUS;
      BUS:     if (bus_done) state_nxt = RESP;
      RESP:    if (rsp_hs)   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Handshake/control outputs decode the state register only.
  always_comb begin
    bus.cmd_ready_o = (state == IDLE);
    bus.wbm_cyc_o   = (state == BUS);
    bus.wbm_stb_o   = (state == BUS);
    bus.rsp_valid_o = (state == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt           <= '0;
      tout_cnt_o    <= '0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_sel_o <= '0;
      bus.wbm_dat_o <= '0;
      bus.wbm_adr_o <= '0;
      bus.rsp_dat_o <= '0;
      bus.rsp_err_o <= 1'b0;
      bus.rsp_tout_o <= 1'b0;
    end else begin
      if (accept) begin
        bus.wbm_we_o  <= bus.cmd_we_i;
        bus.wbm_sel_o <= bus.cmd_sel_i;
        bus.wbm_dat_o <= bus.cmd_dat_i;
        bus.wbm_adr_o <= {bus.cmd_adr_i[31:2], 2'b00};
        cnt           <= '0;
      end else if ((state == BUS) && !bus_done) begin
        cnt <= cnt + TOUT_W'(1);
      end

      // Bus fields return to zero as soon as the cycle ends.
      if (bus_done) begin
        bus.wbm_we_o   <= 1'b0;
        bus.wbm_sel_o  <= '0;
        bus.wbm_dat_o  <= '0;
        bus.wbm_adr_o  <= '0;
        bus.rsp_err_o  <= term_err || term_tout;
        bus.rsp_tout_o <= term_tout;
        bus.rsp_dat_o  <= (term_ack && !bus.wbm_we_o) ? bus.wbm_dat_i : 32'h0;
        if (term_tout && (tout_cnt_o != 8'hFF))
          tout_cnt_o <= tout_cnt_o + 8'd1;
      end

      if (rsp_hs)
        bus.rsp_tout_o <= 1'b0;
    end
  end

endmodule
